// File: rtl/add_pipe_cla.sv
// add_pipe_cla: pipelined carry-lookahead adder/subtractor, one WIDTH/STAGES segment resolved per stage.
// Define ADD_PIPE_FLAGS_EN to build the ovf/zero flag logic; otherwise both flags read 0.
module add_pipe_cla #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ra,
   input  logic [WIDTH-1:0] rb,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rc,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);
   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / 4;
   localparam int L  = STAGES - 1;

   // Returns {carry_out, sum}; groups pass their carry to the next group via group G/P terms.
   function automatic logic [SW:0] seg_add(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic ci);
      logic [SW-1:0] p, g;
      logic [SW:0]   c;
      logic          gg, pg;
      p = a ^ b;
      g = a & b;
      c = '0;
      c[0] = ci;
      for (int j = 0; j < NG; j++) begin
         gg = 1'b0;
         pg = 1'b1;
         for (int i = 4*j; i < 4*j+3; i++) c[i+1] = g[i] | (p[i] & c[i]);
         for (int i = 4*j; i < 4*j+4; i++) begin
            gg = g[i] | (p[i] & gg);
            pg = pg & p[i];
         end
         c[4*j+4] = gg | (pg & c[4*j]);
      end
      return {c[SW], p ^ c[SW-1:0]};
   endfunction

   logic [STAGES-1:0]            v_q, v_d, c_q, c_d, up_v, up_c, en;
   logic [STAGES:0]              ld;
   logic [STAGES-1:0][WIDTH-1:0] r_q, r_d, a_q, a_d, b_q, b_d, up_r, up_a, up_b;
   logic [STAGES-1:0][SW:0]      s;

   always_comb begin
      up_v[0] = in_valid;
      up_c[0] = sub | c_in;
      up_r[0] = '0;
      up_a[0] = ra;
      up_b[0] = sub ? ~rb : rb;
      for (int k = 1; k < STAGES; k++) begin
         up_v[k] = v_q[k-1];
         up_c[k] = c_q[k-1];
         up_r[k] = r_q[k-1];
         up_a[k] = a_q[k-1];
         up_b[k] = b_q[k-1];
      end
      // A stage loads when empty or when the stage after it is loading too.
      ld[STAGES] = out_ready;
      for (int k = L; k >= 0; k--) ld[k] = !v_q[k] || ld[k+1];
      for (int k = 0; k < STAGES; k++) begin
         s[k]   = seg_add(up_a[k][k*SW +: SW], up_b[k][k*SW +: SW], up_c[k]);
         en[k]  = ld[k] && up_v[k];
         v_d[k] = ld[k] ? up_v[k] : v_q[k];
         c_d[k] = en[k] ? s[k][SW] : c_q[k];
         r_d[k] = en[k] ? (up_r[k] | (WIDTH'(s[k][SW-1:0]) << (k*SW))) : r_q[k];
         a_d[k] = en[k] ? up_a[k] : a_q[k];
         b_d[k] = en[k] ? up_b[k] : b_q[k];
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         v_q <= '0;
         c_q <= '0;
         r_q <= '0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         v_q <= v_d;
         c_q <= c_d;
         r_q <= r_d;
         a_q <= a_d;
         b_q <= b_d;
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = v_q[L];
   assign rc        = r_q[L];
   assign c_out     = c_q[L];

`ifdef ADD_PIPE_FLAGS_EN
   logic [STAGES-1:0] z_q, z_d, up_z;
   logic              m_q, m_d;

   always_comb begin
      up_z[0] = 1'b1;
      for (int k = 1; k < STAGES; k++) up_z[k] = z_q[k-1];
      for (int k = 0; k < STAGES; k++) z_d[k] = en[k] ? (up_z[k] & (s[k][SW-1:0] == '0)) : z_q[k];
      // Carry into the MSB recovered from its sum bit and propagate term.
      m_d = en[L] ? (up_a[L][WIDTH-1] ^ up_b[L][WIDTH-1] ^ s[L][SW-1]) : m_q;
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         z_q <= '0;
         m_q <= 1'b0;
      end else begin
         z_q <= z_d;
         m_q <= m_d;
      end
   end

   assign ovf  = m_q ^ c_q[L];
   assign zero = v_q[L] & z_q[L];
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
`endif
endmodule
